// File: rtl/io1in_debounce_if.sv
// Pad-to-core signal bundle for one debounced input pin.
// Optional glitch_cnt is present only when IO1IN_DEBOUNCE_GLITCH_CNT_EN is defined.
interface io1in_debounce_if;
    logic       pin;
    logic       level;
    logic       rise;
    logic       fall;
`ifdef IO1IN_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    // Pad side drives the raw pin and observes the cleaned outputs.
    modport master (
        output pin,
        input  level,
        input  rise,
        input  fall
`ifdef IO1IN_DEBOUNCE_GLITCH_CNT_EN
        ,
        input  glitch_cnt
`endif
    );

    modport slave (
        input  pin,
        output level,
        output rise,
        output fall
`ifdef IO1IN_DEBOUNCE_GLITCH_CNT_EN
        ,
        output glitch_cnt
`endif
    );
endinterface

// File: rtl/io1in_debounce.sv
// Synchronise and debounce one asynchronous pad pin; emits a clean level plus rise/fall pulses.
// Define IO1IN_DEBOUNCE_GLITCH_CNT_EN to add the saturating 8-bit abort counter glitch_cnt.
module io1in_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    io1in_debounce_if.slave    bus
);

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;

`ifdef IO1IN_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0]             glitch_q;
    logic [7:0]             glitch_d;
`endif

    // Only sync_q[0] ever samples the asynchronous pin.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.pin};
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
`ifdef IO1IN_DEBOUNCE_GLITCH_CNT_EN
        glitch_d = glitch_q;
`endif

        unique case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (s != level_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        level_d = ~level_q;
                        rise_d  = ~level_q;
                        fall_d  = level_q;
                    end else begin
                        state_d = CHECK;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            CHECK: begin
                if (s == level_q) begin
                    // Abort: value bounced back before the window filled.
                    state_d = STABLE;
                    cnt_d   = '0;
`ifdef IO1IN_DEBOUNCE_GLITCH_CNT_EN
                    if (glitch_q != 8'hFF) begin
                        glitch_d = glitch_q + 8'd1;
                    end
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                    level_d = ~level_q;
                    rise_d  = ~level_q;
                    fall_d  = level_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef IO1IN_DEBOUNCE_GLITCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign bus.glitch_cnt = glitch_q;
`endif

    assign bus.level = level_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;

endmodule

// File: tb/tb_io1in_debounce.sv
// Scoreboard bench for io1in_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0.
// glitch_cnt checks are compiled in when IO1IN_DEBOUNCE_GLITCH_CNT_EN is defined.
module tb_io1in_debounce;

    localparam int unsigned SS  = 2;
    localparam int unsigned DC  = 4;
    localparam int unsigned CW  = 5;
    localparam logic        RL  = 1'b0;
    localparam int          LAT = SS + DC;  // edges counted from first capture through commit

    typedef struct packed {
        logic       level;
        logic       rise;
        logic       fall;
        logic [7:0] gc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   rise_cnt = 0;
    int   fall_cnt = 0;
    exp_t sbq[$];

    io1in_debounce_if bus ();

    io1in_debounce #(
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (CW),
        .RESET_LEVEL    (RL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: run-length of synchronised samples that disagree with the level.
    logic [SS-1:0] m_sh;
    logic          m_level;
    int            m_run;
    logic [7:0]    m_gc;

    always @(posedge clk) begin
        logic s;
        logic m_rise;
        logic m_fall;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (rst) begin
            m_sh    = {SS{RL}};
            m_level = RL;
            m_run   = 0;
            m_gc    = 8'd0;
        end else begin
            s    = m_sh[SS-1];
            m_sh = {m_sh[SS-2:0], bus.pin};
            if (s != m_level) begin
                m_run++;
                if (m_run == DC) begin
                    m_rise  = ~m_level;
                    m_fall  = m_level;
                    m_level = ~m_level;
                    m_run   = 0;
                end
            end else begin
                if (m_run != 0 && m_gc != 8'hFF) m_gc++;
                m_run = 0;
            end
        end
        sbq.push_back('{level: m_level, rise: m_rise, fall: m_fall, gc: m_gc});
    end

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("level", 32'(bus.level), 32'(e.level));
            check("rise",  32'(bus.rise),  32'(e.rise));
            check("fall",  32'(bus.fall),  32'(e.fall));
`ifdef IO1IN_DEBOUNCE_GLITCH_CNT_EN
            check("glitch_cnt", 32'(bus.glitch_cnt), 32'(e.gc));
`endif
            if (bus.rise === 1'b1) rise_cnt++;
            if (bus.fall === 1'b1) fall_cnt++;
        end
    end

    task automatic wait_level(input logic tgt, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (bus.level !== tgt && n < 50);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r0;
        int f0;
        rst     = 1'b1;
        bus.pin = 1'b0;

        // 1: reset, then quiet low pin
        repeat (3) @(negedge clk);
        check("reset_level", 32'(bus.level), 32'(RL));
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("s1_rise_cnt", 32'(rise_cnt), 32'd0);
        check("s1_fall_cnt", 32'(fall_cnt), 32'd0);
`ifdef IO1IN_DEBOUNCE_GLITCH_CNT_EN
        check("s1_glitch", 32'(bus.glitch_cnt), 32'd0);
`endif

        // 2: clean rise
        r0 = rise_cnt; f0 = fall_cnt;
        bus.pin = 1'b1;
        wait_level(1'b1, n);
        check("s2_latency", 32'(n), 32'(LAT));
        repeat (10) @(negedge clk);
        check("s2_rise_n", 32'(rise_cnt - r0), 32'd1);
        check("s2_fall_n", 32'(fall_cnt - f0), 32'd0);

        // 3: short low glitches, with saturation of the abort counter
        r0 = rise_cnt; f0 = fall_cnt;
        for (int i = 0; i < 300; i++) begin
            bus.pin = 1'b0;
            repeat (3) @(negedge clk);
            bus.pin = 1'b1;
            repeat (4) @(negedge clk);
`ifdef IO1IN_DEBOUNCE_GLITCH_CNT_EN
            if (i == 0) check("s3_glitch_first", 32'(bus.glitch_cnt), 32'd1);
`endif
        end
        check("s3_level", 32'(bus.level), 32'd1);
        check("s3_rise_n", 32'(rise_cnt - r0), 32'd0);
        check("s3_fall_n", 32'(fall_cnt - f0), 32'd0);
`ifdef IO1IN_DEBOUNCE_GLITCH_CNT_EN
        check("s3_glitch_sat", 32'(bus.glitch_cnt), 32'd255);
`endif

        // 4: clean fall
        r0 = rise_cnt; f0 = fall_cnt;
        bus.pin = 1'b0;
        wait_level(1'b0, n);
        check("s4_latency", 32'(n), 32'(LAT));
        repeat (10) @(negedge clk);
        check("s4_fall_n", 32'(fall_cnt - f0), 32'd1);
        check("s4_rise_n", 32'(rise_cnt - r0), 32'd0);

        // 5: reset while counting (cnt=2), then fresh debounce
        r0 = rise_cnt; f0 = fall_cnt;
        bus.pin = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("s5_level_in_rst", 32'(bus.level), 32'd0);
        check("s5_rise_in_rst", 32'(rise_cnt - r0), 32'd0);
        rst = 1'b0;
        wait_level(1'b1, n);
        check("s5_latency", 32'(n), 32'(LAT));
        repeat (10) @(negedge clk);
        check("s5_rise_n", 32'(rise_cnt - r0), 32'd1);
        check("s5_fall_n", 32'(fall_cnt - f0), 32'd0);

        // 6: reset released with pin already high
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("s6_level_in_rst", 32'(bus.level), 32'd0);
        r0 = rise_cnt; f0 = fall_cnt;
        rst = 1'b0;
        wait_level(1'b1, n);
        check("s6_latency", 32'(n), 32'(LAT));
        repeat (20) @(negedge clk);
        check("s6_level", 32'(bus.level), 32'd1);
        check("s6_rise_n", 32'(rise_cnt - r0), 32'd1);
        check("s6_fall_n", 32'(fall_cnt - f0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/io1in_debounce.md
Name: io1in_debounce

Overview:
- Consumer of one fanned-out pad input pin (e.g. pin_0 of the 1-bit input pad block).
- Synchronises the raw asynchronous pin into the clk domain and debounces it.
- Emits a clean level plus single-cycle rise/fall pulses to core logic.
- One instance per used pin; the debounce window is set by parameter.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops (legal 2..4)
DEBOUNCE_CYCLES, 16, consecutive synchronised cycles of a new value required before level changes (legal 1..2**CNT_W-1)
CNT_W, 5, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
RESET_LEVEL, 0, value of the sync chain and level during/after reset

Ports:
clk  input  1  core clock
rst  input  1  synchronous, active-high reset
pin  input  1  raw pad input, asynchronous to clk
level  output  1  debounced, synchronised pin value
rise  output  1  one-cycle pulse on level 0->1
fall  output  1  one-cycle pulse on level 1->0

Behaviour:
- Reset: clock and reset handling is fixed.
  - Single clock clk; rst is synchronous and active-high, sampled on the clk rising edge.
  - Reset values:
    - sync chain = RESET_LEVEL (all stages)
    - level = RESET_LEVEL
    - rise = 0, fall = 0
    - state = STABLE, cnt = 0
    - glitch_cnt = 0 (when the optional feature is enabled)
  - Reset mid-operation aborts any pending transition; no pulse is emitted for it.
- Synchroniser: pin passes through SYNC_STAGES flops; the last stage is s. No other logic reads pin directly.
- The FSM has two states, STABLE and CHECK, and a CNT_W-bit counter cnt. Transitions:
  - STABLE, s == level: hold, cnt = 0.
  - STABLE, s != level, DEBOUNCE_CYCLES == 1: commit immediately.
  - STABLE, s != level, DEBOUNCE_CYCLES > 1: go to CHECK, cnt <= 1.
  - CHECK, s != level, cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - CHECK, s != level, cnt == DEBOUNCE_CYCLES-1: commit.
  - CHECK, s == level: abort. Go to STABLE, cnt <= 0, level unchanged, no pulse; this counts as a glitch.
- Commit:
  - level <= ~level.
  - rise <= ~level (old), fall <= level (old).
  - state <= STABLE, cnt <= 0.
- Pulses:
  - Registered; high for exactly one cycle, coincident with the first cycle of the new level.
  - Otherwise 0; rise and fall are never both high.
- Latency:
  - A clean step on pin, first captured at clock edge E, appears on level/rise/fall after edge E + SYNC_STAGES + DEBOUNCE_CYCLES - 1.
  - It is therefore visible in the cycle following that edge.
- Minimum spacing:
  - Back-to-back transitions need DEBOUNCE_CYCLES stable cycles each.
  - A new counting window starts only from STABLE, never on the commit cycle itself.
- Post-reset behaviour:
  - pin at RESET_LEVEL: no pulse.
  - pin at ~RESET_LEVEL: debounces normally and produces exactly one edge pulse.

Optional Feature:
- Macro: IO1IN_DEBOUNCE_GLITCH_CNT_EN.
- When defined:
  - Adds output port glitch_cnt, 8 bits wide.
  - It is an 8-bit counter that increments by 1 on every abort.
  - It saturates at 255 and clears only on rst.
- When undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0.
1. rst high 3 cycles, pin=0 held 20 cycles -> level=0, rise=fall=0 throughout, glitch_cnt=0.
2. pin 0->1 first captured at edge E, held -> level=1 after edge E+5, rise=1 for exactly that one cycle, fall=0.
3. level=1, pin drops to 0 for 3 cycles then returns to 1 -> level stays 1, no pulses, glitch_cnt=1; repeat 300 times -> glitch_cnt=255.
4. level=1, pin 1->0 held -> level=0 after edge E+5, fall one-cycle pulse, rise=0.
5. pin 0->1, rst asserted 2 cycles while in CHECK (cnt=2), pin held 1 -> level stays 0 through reset with no pulse, then a fresh debounce gives level=1 at the SYNC_STAGES+DEBOUNCE_CYCLES-1 latency with a single rise.
6. rst released with pin=1 held -> exactly one rise pulse at the normal latency, then level=1 stable, no further pulses.
